// File: rtl/jelly_semaphore_multi.sv
// Multi-channel credit semaphore: blocking acquire (valid/ready), fire-and-forget release,
// saturation at MAX_COUNTER. Optional sticky overflow flag via JELLY_SEMAPHORE_MULTI_OVERFLOW_EN.
module jelly_semaphore_multi #(
   parameter int CHANNELS      = 4,
   parameter int COUNTER_WIDTH = 9,
   parameter int INIT_COUNTER  = 256,
   parameter int MAX_COUNTER   = 256,
   localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                              reset,
   input  logic                              clk,
   input  logic [CH_BITS-1:0]                rel_ch,
   input  logic [COUNTER_WIDTH-1:0]          rel_add,
   input  logic                              rel_valid,
   input  logic [CH_BITS-1:0]                req_ch,
   input  logic [COUNTER_WIDTH-1:0]          req_sub,
   input  logic                              req_valid,
   output logic                              req_ready,
   output logic [CHANNELS*COUNTER_WIDTH-1:0] counters,
   output logic [CHANNELS-1:0]               empty,
   output logic                              overflow
);
   localparam int W = COUNTER_WIDTH;
   localparam logic [W-1:0] INIT_VAL = W'(INIT_COUNTER);
   localparam logic [W:0]   MAX_EXT  = (W+1)'(MAX_COUNTER);

   logic [W-1:0] sel_cnt;
   logic         sel_hit;
   logic         acq_fire;

   // Out-of-range channel indices never match, so they are never ready.
   always_comb begin
      sel_cnt = '0;
      sel_hit = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (req_ch == CH_BITS'(i)) begin
            sel_cnt = counters[i*W +: W];
            sel_hit = 1'b1;
         end
      end
   end

   assign req_ready = sel_hit && (sel_cnt >= req_sub);
   assign acq_fire  = req_valid && req_ready;

`ifdef JELLY_SEMAPHORE_MULTI_OVERFLOW_EN
   logic [CHANNELS-1:0] sat;
`endif

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic         rel_hit;
         logic         acq_hit;
         logic [W:0]   tmp;
         logic [W-1:0] cnt_reg;
         logic [W-1:0] cnt_next;
         logic         empty_reg;

         assign rel_hit = rel_valid && (rel_ch == CH_BITS'(gi));
         assign acq_hit = acq_fire && (req_ch == CH_BITS'(gi));

         // One extra bit holds cnt + add; the acquire term never underflows.
         assign tmp = {1'b0, cnt_reg}
                    + (rel_hit ? {1'b0, rel_add} : (W+1)'(0))
                    - (acq_hit ? {1'b0, req_sub} : (W+1)'(0));
         assign cnt_next = (tmp > MAX_EXT) ? MAX_EXT[W-1:0] : tmp[W-1:0];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg   <= INIT_VAL;
               empty_reg <= (INIT_VAL == '0);
            end else begin
               cnt_reg   <= cnt_next;
               empty_reg <= (cnt_next == '0);
            end
         end

         assign counters[gi*W +: W] = cnt_reg;
         assign empty[gi]           = empty_reg;

`ifdef JELLY_SEMAPHORE_MULTI_OVERFLOW_EN
         assign sat[gi] = (tmp > MAX_EXT);
`ifndef SYNTHESIS
         always @(posedge clk) begin
            if (!reset && sat[gi])
               $display("jelly_semaphore_multi: warning, channel %0d saturated at MAX_COUNTER", gi);
         end
`endif
`endif
      end
   endgenerate

`ifdef JELLY_SEMAPHORE_MULTI_OVERFLOW_EN
   logic overflow_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow_reg <= 1'b0;
      else if (|sat)
         overflow_reg <= 1'b1;
   end

   assign overflow = overflow_reg;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_jelly_semaphore_multi.sv
// Scoreboard bench for jelly_semaphore_multi: directed plan plus random traffic against
// an arithmetic credit model. Works with or without JELLY_SEMAPHORE_MULTI_OVERFLOW_EN.
module tb_jelly_semaphore_multi;
   localparam int CH   = 5;
   localparam int CHB  = 3;
   localparam int W    = 9;
   localparam int INIT = 256;
   localparam int MAX  = 256;
`ifdef JELLY_SEMAPHORE_MULTI_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic              reset;
   logic              clk;
   logic [CHB-1:0]    rel_ch;
   logic [W-1:0]      rel_add;
   logic              rel_valid;
   logic [CHB-1:0]    req_ch;
   logic [W-1:0]      req_sub;
   logic              req_valid;
   logic              req_ready;
   logic [CH*W-1:0]   counters;
   logic [CH-1:0]     empty;
   logic              overflow;

   jelly_semaphore_multi #(
      .CHANNELS(CH), .COUNTER_WIDTH(W), .INIT_COUNTER(INIT), .MAX_COUNTER(MAX)
   ) dut (
      .reset(reset), .clk(clk),
      .rel_ch(rel_ch), .rel_add(rel_add), .rel_valid(rel_valid),
      .req_ch(req_ch), .req_sub(req_sub), .req_valid(req_valid), .req_ready(req_ready),
      .counters(counters), .empty(empty), .overflow(overflow)
   );

   typedef struct {
      logic [CH*W-1:0] cnt;
      logic [CH-1:0]   emp;
      logic            ovf;
      logic            rdy;
   } exp_t;

   exp_t exp_q[$];
   int   m_cnt[CH];
   bit   m_ovf;
   int   assertions = 0;
   int   failures   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      assertions++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < CH; i++) m_cnt[i] = INIT;
      m_ovf = 1'b0;
   endfunction

   function automatic exp_t model_snapshot(input bit rdy);
      exp_t e;
      for (int i = 0; i < CH; i++) begin
         e.cnt[i*W +: W] = W'(m_cnt[i]);
         e.emp[i]        = (m_cnt[i] == 0);
      end
      e.ovf = m_ovf;
      e.rdy = rdy;
      return e;
   endfunction

   // One clock of stimulus: drive, queue what the DUT must show now, advance the model.
   task automatic step(input bit rv, input int rc, input int ra,
                       input bit qv, input int qc, input int qs, output bit fired);
      bit rdy;
      int n;
      @(posedge clk);
      #1;
      rel_valid = rv; rel_ch = CHB'(rc); rel_add = W'(ra);
      req_valid = qv; req_ch = CHB'(qc); req_sub = W'(qs);
      rdy = 1'b0;
      if (qc < CH) rdy = (m_cnt[qc] >= qs);
      exp_q.push_back(model_snapshot(rdy));
      fired = qv && rdy;
      for (int i = 0; i < CH; i++) begin
         n = m_cnt[i];
         if (rv && rc == i) n = n + ra;
         if (fired && qc == i) n = n - qs;
         if (n > MAX) begin
            n = MAX;
            if (OVF_EN) m_ovf = 1'b1;
         end
         m_cnt[i] = n;
      end
      $display("txn rel(v=%0d ch=%0d add=%0d) req(v=%0d ch=%0d sub=%0d) ready_exp=%0d fire=%0d",
               rv, rc, ra, qv, qc, qs, rdy, fired);
   endtask

   always @(negedge clk) begin
      if (!reset && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("counters",  64'(counters),  64'(e.cnt));
         check("empty",     64'(empty),     64'(e.emp));
         check("overflow",  64'(overflow),  64'(e.ovf));
         check("req_ready", 64'(req_ready), 64'(e.rdy));
      end
   end

   initial begin
      bit f;
      bit pend;
      int pch, psub, waitc, rv, rc, ra;
      exp_t r;

      reset = 1'b1;
      rel_valid = 0; rel_ch = '0; rel_add = '0;
      req_valid = 0; req_ch = '0; req_sub = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state and full-credit readiness
      step(0, 0, 0, 0, 0, 256, f);
      // Blocking acquire on ch1
      step(0, 0, 0, 1, 1, 200, f);
      step(0, 0, 0, 1, 1, 100, f);
      step(1, 1, 44, 1, 1, 100, f);
      step(0, 0, 0, 1, 1, 100, f);
      step(0, 0, 0, 0, 0, 0, f);
      // Simultaneous release/acquire, same and different channels
      step(0, 0, 0, 1, 2, 246, f);
      step(1, 2, 5, 1, 2, 8, f);
      step(0, 0, 0, 1, 0, 6, f);
      // Saturation: ch0 at 250 + 20
      step(1, 0, 20, 0, 0, 0, f);
      step(0, 0, 0, 1, 0, 30, f);
      step(1, 0, 7, 1, 3, 50, f);
      // Zero request on empty channel, out-of-range channels
      step(0, 0, 0, 1, 1, 0, f);
      step(0, 0, 0, 1, 5, 0, f);
      step(1, 5, 100, 0, 0, 0, f);
      step(1, 7, 1, 1, 6, 10, f);
      step(0, 0, 0, 0, 0, 0, f);

      // Random traffic with a held-until-granted requester
      pend = 0; pch = 0; psub = 0; waitc = 0;
      for (int n = 0; n < 400; n++) begin
         if (!pend && $urandom_range(0, 2) != 0) begin
            pend = 1; pch = $urandom_range(0, CH-1); psub = $urandom_range(0, 256); waitc = 0;
         end
         rv = $urandom_range(0, 1); rc = $urandom_range(0, 7); ra = $urandom_range(0, 120);
         if (pend && waitc > 6) begin
            rv = 1; rc = pch; ra = psub;
         end
         step(rv[0], rc, ra, pend, pch, psub, f);
         if (f) pend = 0;
         else waitc++;
      end

      // Force a saturation so overflow is set (with the macro) before the async reset
      step(1, 4, 300, 1, 2, 0, f);
      step(0, 0, 0, 0, 0, 0, f);
      @(negedge clk);

      // Asynchronous reset mid-operation, checked before any clock edge
      @(posedge clk);
      #1;
      rel_valid = 1; rel_ch = 3'd1; rel_add = 9'd10;
      req_valid = 1; req_ch = 3'd2; req_sub = 9'd1;
      #1 reset = 1'b1;
      #1;
      model_reset();
      r = model_snapshot(1'b0);
      check("async_reset_counters", 64'(counters), 64'(r.cnt));
      check("async_reset_empty",    64'(empty),    64'(r.emp));
      check("async_reset_overflow", 64'(overflow), 64'(r.ovf));
      rel_valid = 0; req_valid = 0;
      @(posedge clk);
      #1 reset = 1'b0;

      step(0, 0, 0, 1, 0, 256, f);
      step(0, 0, 0, 0, 0, 0, f);
      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
